// File: rtl/display_arbiter.sv
// ============================================================================
// Module   : display_arbiter
// Purpose  : Round-robin, minimum-dwell arbiter sharing one 4-digit display
//            between NUM_REQ requesters. Optional macro DISPLAY_ARB_PRIORITY_EN
//            lets requester 0 preempt other owners.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_arbiter #(
    parameter int          NUM_REQ = 3,
    parameter logic [15:0] DWELL   = 16'd50000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [16*NUM_REQ-1:0]  req_number,
    input  logic [NUM_REQ-1:0]     req_blank,
    output logic [NUM_REQ-1:0]     grant,
    output logic [1:0]             owner,
    output logic [15:0]            number,
    output logic                   display_lines
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [1:0]           last_q, last_d;
    logic [1:0]           owner_q, owner_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [15:0]          number_q, number_d;
    logic                 lines_q, lines_d;

    logic                 w_take;
    logic                 w_go_idle;
    logic [1:0]           w_nxt;
    logic                 w_own_req;
    logic [NUM_REQ-1:0]   w_others;
    logic [3:0]           w_blank4;
    logic [63:0]          w_num64;
    logic [3:0]           w_grant4;

    // First set bit of mask searching base+1, base+2, ... wrapping to base.
    function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                           input logic [1:0]         base);
        logic [3:0] m4;
        logic [1:0] pick;
        logic [1:0] cand;
        logic       found;
        int         idx;
        m4    = 4'(mask);
        pick  = base;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx  = (int'(base) + k) % NUM_REQ;
            cand = idx[1:0];
            if (!found && m4[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign w_own_req = |(req & grant_q);
    assign w_others  = req & ~grant_q;
    assign w_blank4  = 4'(req_blank);
    assign w_num64   = 64'(req_number);
    assign w_grant4  = 4'b0001 << w_nxt;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        w_take    = 1'b0;
        w_go_idle = 1'b0;
        w_nxt     = owner_q;

        if (state_q == S_IDLE) begin
            if (|req) begin
                w_take = 1'b1;
                w_nxt  = rr_pick(req, last_q);
            end else begin
                w_go_idle = 1'b1;
            end
        end else begin
            if (cnt_q != DWELL) begin
                cnt_d = cnt_q + 16'd1;
            end
`ifdef DISPLAY_ARB_PRIORITY_EN
            if (req[0] && !grant_q[0]) begin
                w_take = 1'b1;
                w_nxt  = 2'd0;
            end else
`endif
            if (!w_own_req) begin
                if (|w_others) begin
                    w_take = 1'b1;
                    w_nxt  = rr_pick(w_others, last_q);
                end else begin
                    w_go_idle = 1'b1;
                end
            end else if ((cnt_q >= DWELL - 16'd1) && (|w_others)) begin
                w_take = 1'b1;
                w_nxt  = rr_pick(w_others, last_q);
            end
        end

        if (w_take) begin
            state_d = S_HOLD;
            cnt_d   = 16'd0;
            last_d  = w_nxt;
        end
        if (w_go_idle) begin
            state_d = S_IDLE;
            cnt_d   = 16'd0;
        end

        // Outputs are loaded every cycle so the owner's value tracks live.
        if (w_go_idle) begin
            grant_d  = '0;
            owner_d  = owner_q;
            number_d = 16'd0;
            lines_d  = 1'b1;
        end else begin
            grant_d  = w_grant4[NUM_REQ-1:0];
            owner_d  = w_nxt;
            number_d = w_num64[{w_nxt, 4'b0000} +: 16];
            lines_d  = w_blank4[w_nxt];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 16'd0;
            last_q   <= 2'(NUM_REQ - 1);
            owner_q  <= 2'd0;
            grant_q  <= '0;
            number_q <= 16'd0;
            lines_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            grant_q  <= grant_d;
            number_q <= number_d;
            lines_q  <= lines_d;
        end
    end

    assign grant         = grant_q;
    assign owner         = owner_q;
    assign number        = number_q;
    assign display_lines = lines_q;

endmodule

`default_nettype wire

// File: doc/display_arbiter.md
# display_arbiter

Time-shares the single 4-digit seven-segment `Display` between up to four requesters, e.g. score, cleared-line count and a status or debug value. Each requester raises a level request and presents a live 16-bit number plus a blank flag. The arbiter grants one owner at a time, using round-robin with a minimum dwell time. It drives the `Display` inputs `number` and `display_lines` from registers.

## Interface
- `NUM_REQ`, default 3: number of requesters; legal values are 2..4.
- `DWELL`, default 16'd50000: minimum grant length in clock cycles while contended; legal range 1..65535.
- `clk`  in  1: system clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `req`  in  NUM_REQ: level request, one bit per requester.
- `req_number`  in  16*NUM_REQ: live value for each requester; requester i occupies bits [16i+15:16i].
- `req_blank`  in  NUM_REQ: requester wants the dash pattern instead of digits.
- `grant`  out  NUM_REQ: one-hot current owner, registered; all zero when idle.
- `owner`  out  2: index of the current owner, registered; holds its last value when idle.
- `number`  out  16: value fed to `Display.number`, registered.
- `display_lines`  out  1: fed to `Display.display_lines`, registered.

## Operation
- Two states:
  - IDLE: no grant.
  - HOLD: one owner holds the grant.
- A 16-bit dwell counter `cnt` runs in HOLD.
- A register `last` holds the index of the most recent owner.
- Round-robin pick:
  - Search the indices `last+1`, `last+2`, … modulo NUM_REQ, ending with `last` itself.
  - The first index with `req` set wins.
- IDLE:
  - If any `req` bit is set, grant the pick, set `last` to the pick, clear `cnt`, and go to HOLD.
  - Otherwise drive `number` = 0 and `display_lines` = 1.
- HOLD, owner `o`:
  - Each cycle, `number` is loaded from `req_number[o]` and `display_lines` from `req_blank[o]`, so value updates track live.
  - `cnt` increments and saturates at DWELL.
  - If `req[o]` = 0: release immediately. If others are requesting, grant the round-robin pick; otherwise go to IDLE.
  - If `cnt` ≥ DWELL-1 and any other `req` bit is set: switch to the round-robin pick (never `o` itself) and clear `cnt`.
  - If there is no contention, `o` keeps the grant indefinitely.
- Requests on indices ≥ NUM_REQ do not exist.
- Reset values:
  - state IDLE
  - `grant` = 0
  - `owner` = 0
  - `last` = NUM_REQ-1, so requester 0 wins the first pick
  - `cnt` = 0
  - `number` = 0
  - `display_lines` = 1

## Timing
- Grant latency: `req` sampled high at edge t while idle gives `grant`, `owner`, `number` and `display_lines` valid after edge t+1.
- Data latency: a change in `req_number[o]` at edge t appears on `number` after edge t+1.
- Dwell: a contended owner keeps the grant for exactly DWELL cycles of `grant` high. With DWELL = 1, contended owners alternate every cycle.
- Release: the owner drops `req` at edge t; the new grant, or IDLE outputs, appear after edge t+1. There is no gap cycle between owners.
- Simultaneous events: owner release and dwell expiry in the same cycle are handled as a release; the next owner comes from the round-robin pick.
- Reset asserted mid-HOLD clears all state asynchronously. After release, arbitration restarts from requester 0.
- `Display` samples `number` only at its digit-3 rollover, so a switch becomes visible within one refresh frame.

## Configuration
- `DISPLAY_ARB_PRIORITY_EN` defined:
  - Requester 0 preempts. If `req[0]` = 1 while another index owns, requester 0 is granted on the next edge regardless of `cnt`.
  - While requester 0 owns, the dwell rule still applies to it, and other requesters get turns once its dwell has expired.
- Undefined: pure round-robin; requester 0 has no special treatment.

## Test plan
- Reset and idle: after `reset_n` is released with `req` = 0 → `grant` = 000, `number` = 0, `display_lines` = 1 on every cycle.
- Single requester: `req` = 010, `req_number[1]` = 16'h1234, then 16'h00AB two cycles later → `grant` = 010 one cycle after `req`; `number` follows each value with 1 cycle of latency.
- Contention (DWELL = 4): `req` = 111 held → grant sequence 001,001,001,001,010×4,100×4,001… with no gaps.
- Early release (DWELL = 4): requester 0 owns, `req` goes 011 → 010 at cnt = 1 → `grant` = 010 on the next edge.
- Preempt, macro on (DWELL = 100): requester 2 owns at cnt = 5 and `req[0]` rises → `grant` = 001 next edge. With the macro off → `grant` remains 100 until cnt = 99.
- Async reset mid-HOLD: `reset_n` goes low while `grant` = 100 → `grant` = 000 and `display_lines` = 1 with no clock edge; after release with `req` = 111 → `grant` = 001.
